regfile_write_sched: RTL
========================

// Module: regfile_write_sched
// PURPOSE
//  Shares the single write port of the 16-bit register file between NUM_REQ requesters.
//  Round-robin arbitration selects one request per cycle.
//  It drives the one-hot enable bus (one en per register instance) and the shared D bus.
//  A per-register pending scoreboard covers the 2-edge register latency (D->internal->Q),
//  so readers know when Q is stale. The block sits between the requesters and the register array.
// PARAMETERS
//  NUM_REGS  8                   number of register instances driven
//  NUM_REQ   2                   number of write requesters (>=1)
//  DW        16                  data width
//  AW        $clog2(NUM_REGS)    register address width
// PORTS
//  clk        in   1             rising-edge clock
//  rst_n      in   1             asynchronous active-low reset
//  req_valid  in   NUM_REQ       write request per requester; held until accepted
//  req_ready  out  NUM_REQ       grant; at most one bit high per cycle
//  req_addr   in   NUM_REQ*AW    target register, slice i for requester i
//  req_data   in   NUM_REQ*DW    write data, slice i for requester i
//  reg_en     out  NUM_REGS      one-hot register enable (drives each register's en)
//  reg_d      out  DW            shared register D bus
//  pending    out  NUM_REGS      1 = a write to that register is not yet visible on its Q
//  busy       out  1             |pending
//  done       out  NUM_REQ       (REGSCHED_DONE_EN only) write-visible pulse
// BEHAVIOUR
//  Reset (async, rst_n=0): reg_en=0, reg_d=0, pending=0, done=0, rr pointer=0.
//    Requester 0 has first priority after reset.
//  Handshake:
//    - req_ready is combinational from req_valid and the rr pointer.
//    - Requesters must not make valid depend on ready.
//    - Accept = req_valid[i] & req_ready[i] at rising edge E0.
//    - Valid/addr/data must stay stable until accepted.
//  Arbitration: round-robin.
//    - Search starts at the index after the last accepted requester, wrapping NUM_REQ-1 -> 0.
//    - The pointer updates only on accept. One accept per cycle, so a write can be accepted every cycle.
//  Latency:
//    - Accept at E0 -> reg_en[addr]=1 and reg_d=data for exactly the cycle E0..E1.
//    - The register captures at E1; its Q is valid after E2.
//    - With no accept at E0, reg_en=0 for that cycle and reg_d holds its last value.
//  Pending scoreboard (two-stage shift per register):
//    - set at E0 on accept; cleared after E2 unless a newer accept to the same register is in flight.
//    - Back-to-back writes to the same register: both go out in order; pending stays high until 2 edges after the last one.
//  Out-of-range address (addr >= NUM_REGS, non-power-of-2 NUM_REGS):
//    - the request is accepted and dropped; reg_en stays 0 and pending is unchanged.
//  No address hazard stall: the scheduler never blocks on pending; only readers consult it.
//  Reset mid-operation:
//    - in-flight writes are abandoned and reg_en drops immediately.
//    - the scoreboard clears even if the register already captured the data.
// CONFIGURATION
//  REGSCHED_DONE_EN defined:
//    - done[i] pulses for 1 cycle, E2..E3, for requester i's accepted write.
//    - This is the cycle its data is first valid on the register's Q.
//    - Dropped out-of-range writes still pulse done at the same time.
//    - Multiple done bits are never high together (one accept per cycle).
//  Not defined: done port absent; no tracking logic for requester IDs.
// TESTING
//  1 Reset: assert rst_n=0 mid-cycle with req_valid=2'b11
//      -> reg_en=0, pending=0, req_ready=2'b01 immediately after release.
//  2 Single write: req0 addr=3 data=16'hA5A5, accept at E0
//      -> reg_en=8'b0000_1000 and reg_d=A5A5 for one cycle.
//      -> pending[3] high E0..E2; register 3's Q=A5A5 after E2.
//  3 Contention: both valid for 4 cycles, req0 addr=1 and req1 addr=2
//      -> grants alternate 0,1,0,1.
//      -> reg_en alternates 8'h02/8'h04 one cycle later.
//  4 Same-register burst: req0 writes addr=5 with 1,2,3 on consecutive cycles
//      -> register 5's Q steps 1,2,3.
//      -> pending[5] stays high until 2 edges after the 3rd accept.
//  5 Out of range: NUM_REGS=6, addr=7
//      -> accepted; reg_en=0 and pending unchanged.
//  6 REGSCHED_DONE_EN: req1 addr=0 data=16'h1234 accepted at E0
//      -> done=2'b10 for E2..E3 while register 0's Q=1234.
//      -> without the macro, the port is absent.

Source files
------------

// File: rtl/regfile_write_sched.sv
`timescale 1ns/1ps
// regfile_write_sched
// Shares the single write port of a register array between NUM_REQ requesters.
// A round-robin arbiter picks one request per cycle. The winner drives the
// one-hot enable bus and the shared D bus for exactly one cycle. A two-stage
// scoreboard marks each register whose Q does not yet show its newest write.
// Out-of-range addresses (non-power-of-2 NUM_REGS) are accepted and dropped.
// Optional feature: define REGSCHED_DONE_EN to add the done[] port. It pulses
// for the requester whose write has just become visible on Q.
module regfile_write_sched #(
  parameter int NUM_REGS = 8,
  parameter int NUM_REQ  = 2,
  parameter int DW       = 16,
  parameter int AW       = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*AW-1:0] req_addr,
  input  logic [NUM_REQ*DW-1:0] req_data,
  output logic [NUM_REGS-1:0]   reg_en,
  output logic [DW-1:0]         reg_d,
  output logic [NUM_REGS-1:0]   pending,
  output logic                  busy
`ifdef REGSCHED_DONE_EN
  ,
  output logic [NUM_REQ-1:0]    done
`endif
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [IW-1:0]       rr_ptr;      // first requester to consider this cycle
  logic [IW-1:0]       next_ptr;
  logic [IW-1:0]       grant_idx;
  logic                grant_found; // doubles as "accept": ready is only raised on a valid
  logic [NUM_REQ-1:0]  valid_rot;
  logic [AW-1:0]       sel_addr;
  logic [DW-1:0]       sel_data;
  logic [NUM_REGS-1:0] en_next;
  logic [NUM_REGS-1:0] pend_tail;   // second scoreboard stage: register captured, Q not yet valid

  // Round-robin search: rotate valid so rr_ptr sits at bit 0, then take the first set bit.
  // NOTE: every signal written here gets a default at the top of the block.
  // Any path that leaves a signal unassigned would infer a latch.
  always_comb begin
    int sum;
    sum         = 0;
    grant_found = 1'b0;
    grant_idx   = '0;
    valid_rot   = NUM_REQ'({req_valid, req_valid} >> rr_ptr);
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!grant_found && valid_rot[k]) begin
        grant_found = 1'b1;
        sum         = int'(rr_ptr) + k;
        if (sum >= NUM_REQ) sum = sum - NUM_REQ;
        grant_idx   = IW'(sum);
      end
    end
  end

  // Grant vector, the winner's address/data, next-cycle enable decode, and the pointer advance.
  always_comb begin
    req_ready = '0;
    sel_addr  = '0;
    sel_data  = '0;
    en_next   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_found && (grant_idx == IW'(i))) begin
        req_ready[i] = 1'b1;
        sel_addr     = req_addr[i*AW +: AW];
        sel_data     = req_data[i*DW +: DW];
      end
    end
    // An address with no matching register leaves en_next all-zero. The write is dropped.
    for (int r = 0; r < NUM_REGS; r++) begin
      en_next[r] = grant_found && (int'(sel_addr) == r);
    end
    next_ptr = (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;
  end

  // Write-port registers: enable pulse, held D bus, scoreboard tail and arbitration pointer.
  // NOTE: sequential state uses non-blocking assignments only.
  // pend_tail therefore samples the old reg_en, which forms the two-stage shift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr    <= '0;
      reg_en    <= '0;
      reg_d     <= '0;
      pend_tail <= '0;
    end else begin
      reg_en    <= en_next;
      pend_tail <= reg_en;
      if (grant_found) begin
        rr_ptr <= next_ptr;
        reg_d  <= sel_data;
      end
    end
  end

  // A register is stale while its write is on the bus or still inside the register.
  // A newer write to the same register re-arms the first stage, so pending stays high.
  assign pending = reg_en | pend_tail;
  assign busy    = |pending;

`ifdef REGSCHED_DONE_EN
  logic          trk1_v, trk2_v;
  logic [IW-1:0] trk1_id, trk2_id;

  // Carry the requester ID alongside the write so done fires when Q first shows the data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trk1_v  <= 1'b0;
      trk2_v  <= 1'b0;
      trk1_id <= '0;
      trk2_id <= '0;
      done    <= '0;
    end else begin
      trk1_v  <= grant_found;
      trk1_id <= grant_idx;
      trk2_v  <= trk1_v;
      trk2_id <= trk1_id;
      for (int i = 0; i < NUM_REQ; i++) begin
        done[i] <= trk2_v && (trk2_id == IW'(i));
      end
    end
  end
`endif

endmodule
